// File: rtl/scandoubler_rotate_sdram_port_if.sv
// rtl/scandoubler_rotate_sdram_port_if.sv - word-wide SDRAM command/data port between cornerturn stage and memory controller
interface scandoubler_rotate_sdram_port_if #(
  parameter int ADDR_WIDTH = 24
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [15:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/scandoubler_rotate_sdram_port.sv
// rtl/scandoubler_rotate_sdram_port.sv - cornerturn between vidin/vidout streams and one SDRAM word port
// Optional feature macro: SCANDOUBLER_ROTATE_PORT_STATS_EN adds the stat_wr_wait output.
module scandoubler_rotate_sdram_port #(
  parameter int          ADDR_WIDTH = 24,
  parameter int unsigned BASE       = 0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        vidin_req,
  input  logic        vidin_frame,
  input  logic [9:0]  vidin_row,
  input  logic [9:0]  vidin_col,
  input  logic [15:0] vidin_d,
  output logic        vidin_ack,
  input  logic        vidout_req,
  input  logic        vidout_frame,
  input  logic [9:0]  vidout_row,
  input  logic [9:0]  vidout_col,
  output logic [15:0] vidout_d,
  output logic        vidout_ack,
`ifdef SCANDOUBLER_ROTATE_PORT_STATS_EN
  output logic [7:0]  stat_wr_wait,
`endif
  scandoubler_rotate_sdram_port_if.master mem
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETTLE,
    WR_CMD,
    WR_GAP,
    RD_CMD,
    RD_DATA
  } state_t;

  state_t     state;
  logic [3:0] wcnt;
  logic [2:0] rcnt;
  logic       dly;
  logic       rd_owed;
  logic       start_wr;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic       frame,
                                                      input logic [9:0] major,
                                                      input logic [9:0] minor);
    return ADDR_WIDTH'(BASE) + ADDR_WIDTH'({frame, major, minor});
  endfunction

  assign start_wr = (state == IDLE) && vidin_req && !rd_owed;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wcnt          <= '0;
      rcnt          <= '0;
      dly           <= 1'b0;
      rd_owed       <= 1'b0;
      vidin_ack     <= 1'b0;
      vidout_ack    <= 1'b0;
      vidout_d      <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      vidin_ack  <= 1'b0;
      vidout_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start_wr) begin
            state <= WR_SETTLE;
            dly   <= 1'b0;
          end else if (vidout_req) begin
            state        <= RD_CMD;
            rd_owed      <= 1'b0;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= word_addr(vidout_frame, vidout_row, vidout_col);
          end else begin
            // An owed read whose requester has gone away must not block writes.
            rd_owed <= 1'b0;
          end
        end
        WR_SETTLE: begin
          if (dly) begin
            state         <= WR_CMD;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= word_addr(vidin_frame, vidin_col, vidin_row);
            mem.mem_wdata <= vidin_d;
          end else begin
            dly <= 1'b1;
          end
        end
        WR_CMD: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            vidin_ack   <= 1'b1;
            wcnt        <= wcnt + 4'd1;
            dly         <= 1'b0;
            if (wcnt == 4'd15) begin
              state   <= WR_GAP;
              rd_owed <= vidout_req;
            end else begin
              state <= WR_SETTLE;
            end
          end
        end
        WR_GAP: begin
          if (dly) state <= IDLE;
          else     dly   <= 1'b1;
        end
        RD_CMD: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            rcnt        <= '0;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Ack spacing follows rvalid spacing; the controller never returns back-to-back words.
          if (mem.mem_rvalid) begin
            vidout_d   <= mem.mem_rdata;
            vidout_ack <= 1'b1;
            rcnt       <= rcnt + 3'd1;
            if (rcnt == 3'd7) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCANDOUBLER_ROTATE_PORT_STATS_EN
  logic       wr_waiting;
  logic [7:0] wr_wait_cnt;
  logic [7:0] wr_wait_next;
  logic       frame_q;

  assign wr_wait_next = (wr_wait_cnt == 8'hFF) ? 8'hFF : wr_wait_cnt + 8'd1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_waiting   <= 1'b0;
      wr_wait_cnt  <= '0;
      frame_q      <= 1'b0;
      stat_wr_wait <= '0;
    end else begin
      frame_q <= vidin_frame;
      if (start_wr) begin
        wr_waiting  <= 1'b1;
        wr_wait_cnt <= '0;
      end else if (wr_waiting) begin
        wr_wait_cnt <= wr_wait_next;
        if (state == WR_CMD && mem.mem_ack) begin
          wr_waiting <= 1'b0;
          if (wr_wait_next > stat_wr_wait) stat_wr_wait <= wr_wait_next;
        end
      end
      if (vidin_frame != frame_q) stat_wr_wait <= '0;
    end
  end
`else
  // Statistics disabled: no wait counters are built.
`endif

endmodule

// File: tb/tb_scandoubler_rotate_sdram_port.sv
// tb/tb_scandoubler_rotate_sdram_port.sv - directed scoreboard bench for scandoubler_rotate_sdram_port
module tb_scandoubler_rotate_sdram_port;
  localparam int          AW   = 24;
  localparam int unsigned BASE = 32'h40_0000;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
  } cmd_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        vidin_req, vidin_frame, vidin_ack;
  logic [9:0]  vidin_row, vidin_col;
  logic [15:0] vidin_d;
  logic        vidout_req, vidout_frame, vidout_ack;
  logic [9:0]  vidout_row, vidout_col;
  logic [15:0] vidout_d;
`ifdef SCANDOUBLER_ROTATE_PORT_STATS_EN
  logic [7:0]  stat_wr_wait;
`endif

  scandoubler_rotate_sdram_port_if #(.ADDR_WIDTH(AW)) mem_if ();

  scandoubler_rotate_sdram_port #(.ADDR_WIDTH(AW), .BASE(BASE)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .vidin_req    (vidin_req),
    .vidin_frame  (vidin_frame),
    .vidin_row    (vidin_row),
    .vidin_col    (vidin_col),
    .vidin_d      (vidin_d),
    .vidin_ack    (vidin_ack),
    .vidout_req   (vidout_req),
    .vidout_frame (vidout_frame),
    .vidout_row   (vidout_row),
    .vidout_col   (vidout_col),
    .vidout_d     (vidout_d),
    .vidout_ack   (vidout_ack),
`ifdef SCANDOUBLER_ROTATE_PORT_STATS_EN
    .stat_wr_wait (stat_wr_wait),
`endif
    .mem          (mem_if.master)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          wr_acks = 0;
  cmd_t        exp_cmd[$];
  logic [15:0] exp_rd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int frame, input int major, input int minor);
    return AW'(BASE + frame * (1 << 20) + major * 1024 + minor);
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      chk("idle_mem_req", 32'(mem_if.mem_req), 0);
    end
  endtask

  task automatic serve_cmd(input int ack_delay);
    cmd_t e;
    int   n;
    n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("mem_req_rise", 32'(mem_if.mem_req), 1);
    e = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : '0;
    chk("mem_we", 32'(mem_if.mem_we), 32'(e.we));
    chk("mem_addr", 32'(mem_if.mem_addr), 32'(e.addr));
    if (e.we) chk("mem_wdata", 32'(mem_if.mem_wdata), 32'(e.wdata));
    if (ack_delay > 0) begin
      repeat (ack_delay) @(negedge clk_sys);
      chk("mem_req_held", 32'(mem_if.mem_req), 1);
    end
    mem_if.mem_ack = 1'b1;
    @(negedge clk_sys);
    mem_if.mem_ack = 1'b0;
    chk("mem_req_drop", 32'(mem_if.mem_req), 0);
    chk("vidin_ack", 32'(vidin_ack), 32'(e.we));
    if (vidin_ack === 1'b1) wr_acks++;
  endtask

  task automatic write_burst(input int frame, input int row, input int col0, input int nwords,
                             input bit drop, input int first_delay);
    for (int i = 0; i < nwords; i++) begin
      vidin_frame = frame[0];
      vidin_row   = 10'(row);
      vidin_col   = 10'(col0 + i);
      vidin_d     = 16'($urandom);
      exp_cmd.push_back({1'b1, exp_addr(frame, col0 + i, row), vidin_d});
      vidin_req   = 1'b1;
      serve_cmd(i == 0 ? first_delay : 0);
      if (drop && i == nwords - 1) vidin_req = 1'b0;
      @(negedge clk_sys);
      chk("vidin_ack_pulse", 32'(vidin_ack), 0);
    end
  endtask

  task automatic read_burst(input int frame, input int row, input int col, input int data0,
                            input int drop_after);
    vidout_frame = frame[0];
    vidout_row   = 10'(row);
    vidout_col   = 10'(col);
    vidout_req   = 1'b1;
    exp_cmd.push_back({1'b0, exp_addr(frame, row, col), 16'h0});
    serve_cmd(1);
    for (int k = 0; k < 8; k++) begin
      repeat ((k % 3) + 1) begin
        @(negedge clk_sys);
        chk("vidout_ack_gap", 32'(vidout_ack), 0);
      end
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 16'(data0 + k);
      exp_rd.push_back(16'(data0 + k));
      @(negedge clk_sys);
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 16'hDEAD;
      chk("vidout_ack", 32'(vidout_ack), 1);
      if (exp_rd.size() > 0) chk("vidout_d", 32'(vidout_d), 32'(exp_rd.pop_front()));
      if (k + 1 == drop_after) vidout_req = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    vidin_req = 1'b0; vidin_frame = 1'b0; vidin_row = '0; vidin_col = '0; vidin_d = '0;
    vidout_req = 1'b0; vidout_frame = 1'b0; vidout_row = '0; vidout_col = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_mem_req", 32'(mem_if.mem_req), 0);
    chk("rst_mem_we", 32'(mem_if.mem_we), 0);
    chk("rst_mem_addr", 32'(mem_if.mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_if.mem_wdata), 0);
    chk("rst_vidin_ack", 32'(vidin_ack), 0);
    chk("rst_vidout_ack", 32'(vidout_ack), 0);
    chk("rst_vidout_d", 32'(vidout_d), 0);
`ifdef SCANDOUBLER_ROTATE_PORT_STATS_EN
    chk("rst_stat", 32'(stat_wr_wait), 0);
`endif
    reset_n = 1'b1;
    @(negedge clk_sys);

    // stray ack/rvalid while idle must be ignored
    mem_if.mem_ack = 1'b1; mem_if.mem_rvalid = 1'b1;
    @(negedge clk_sys);
    mem_if.mem_ack = 1'b0; mem_if.mem_rvalid = 1'b0;
    @(negedge clk_sys);
    chk("stray_vidin_ack", 32'(vidin_ack), 0);
    chk("stray_vidout_ack", 32'(vidout_ack), 0);
    chk("stray_mem_req", 32'(mem_if.mem_req), 0);

    // single write burst, transposed addressing
    wr_acks = 0;
    write_burst(0, 5, 32, 16, 1'b1, 0);
    chk("wr_ack_count", 32'(wr_acks), 16);
    idle_check(6);

    // read burst with gapped rvalid
    read_burst(1, 7, 16, 'hA000, 8);
    idle_check(6);

    // requester drops after third word, burst still completes
    read_burst(0, 3, 0, 'h5100, 3);
    idle_check(8);

    // contention: write, then owed read, then next write
    vidout_frame = 1'b1; vidout_row = 10'd2; vidout_col = 10'd40; vidout_req = 1'b1;
    write_burst(0, 9, 0, 16, 1'b0, 0);
    read_burst(1, 2, 40, 'hC000, 8);
    write_burst(0, 10, 0, 6, 1'b0, 0);

    // asynchronous reset mid-burst
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_if.mem_req), 0);
    chk("arst_mem_we", 32'(mem_if.mem_we), 0);
    chk("arst_mem_addr", 32'(mem_if.mem_addr), 0);
    chk("arst_mem_wdata", 32'(mem_if.mem_wdata), 0);
    chk("arst_vidout_d", 32'(vidout_d), 0);
    vidin_req = 1'b0; vidout_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    vidout_frame = 1'b0; vidout_row = 10'd1; vidout_col = 10'd8; vidout_req = 1'b1;
    write_burst(0, 11, 0, 16, 1'b1, 0);
    read_burst(0, 1, 8, 'hE000, 8);
    idle_check(6);

`ifdef SCANDOUBLER_ROTATE_PORT_STATS_EN
    write_burst(1, 20, 100, 16, 1'b1, 300);
    chk("stat_saturated", 32'(stat_wr_wait), 255);
    vidin_frame = 1'b0;
    @(negedge clk_sys);
    chk("stat_cleared", 32'(stat_wr_wait), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
